dmem_responder: RTL and testbench

Data-memory responder for the 5-stage pipelined CPU. It services load and store requests that the MEM stage issues over a valid/ready request channel, and returns one response per request over a valid/ready response channel after a configurable number of wait states. It contains the word-addressed data array, a wait-state counter, and a three-state request/response FSM. Compared with the CPU's zero-latency ideal memory, this block is the far end of the MEM-stage memory interface.

---
 rtl/ppcpu_pkg.sv | 11 +
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_ram.sv | 20 ++
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/ppcpu_pkg.sv
// Shared CPU-side memory definitions: responder FSM states and datapath widths.
package ppcpu_pkg;
  localparam int WORD_W = 32;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory request/response channel (valid/ready both ways).
interface dmem_responder_if;
  import ppcpu_pkg::*;

  logic              Req_Valid;
  logic              Req_Ready;
  logic              Req_Wr;
  logic [WORD_W-1:0] Req_Addr;
  logic [WORD_W-1:0] Req_Wdata;
  logic              Rsp_Valid;
  logic              Rsp_Ready;
  logic [WORD_W-1:0] Rsp_Rdata;
  logic              Rsp_Err;

  modport master (
    output Req_Valid, Req_Wr, Req_Addr, Req_Wdata, Rsp_Ready,
    input  Req_Ready, Rsp_Valid, Rsp_Rdata, Rsp_Err
  );

  modport slave (
    input  Req_Valid, Req_Wr, Req_Addr, Req_Wdata, Rsp_Ready,
    output Req_Ready, Rsp_Valid, Rsp_Rdata, Rsp_Err
  );
endinterface

// File: rtl/dmem_ram.sv
// Single-port word array: synchronous write, asynchronous read. Contents are not reset.
module dmem_ram
  import ppcpu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYC cycles, then responds.
// Optional misaligned-access error reporting is enabled by defining DMEM_ALIGN_CHK_EN.
module dmem_responder
  import ppcpu_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic           Clk,
  input  logic           Clrn,
  dmem_responder_if.slave bus,
  output logic           Busy
);
  state_t              state, state_nx;
  logic [WAIT_W-1:0]   cnt;
  logic                lat_wr;
  logic [ADDR_W-1:0]   lat_idx;
  logic [WORD_W-1:0]   lat_wdata;
  logic                do_acc;
  logic                acc_wr;
  logic [ADDR_W-1:0]   acc_idx;
  logic [WORD_W-1:0]   acc_wdata;
  logic [WORD_W-1:0]   ram_rdata;
  logic                mis;
  logic [WORD_W-1:0]   rsp_rdata;
  logic                unused_addr;

  assign unused_addr = ^{bus.Req_Addr[WORD_W-1:ADDR_W+2], bus.Req_Addr[1:0]};

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_acc   = 1'b0;
    case (state)
      IDLE: if (bus.Req_Valid) begin
        if (WAIT_CYC == 0) begin
          state_nx = RESP;
          do_acc   = 1'b1;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: if (cnt <= WAIT_W'(1)) begin
        state_nx = RESP;
        do_acc   = 1'b1;
      end
      RESP: if (bus.Rsp_Ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so it must
  // see the live request rather than the latched copy.
  assign acc_wr    = (state == IDLE) ? bus.Req_Wr                   : lat_wr;
  assign acc_idx   = (state == IDLE) ? bus.Req_Addr[ADDR_W+1:2]     : lat_idx;
  assign acc_wdata = (state == IDLE) ? bus.Req_Wdata                : lat_wdata;

`ifdef DMEM_ALIGN_CHK_EN
  logic [1:0] lat_off;
  logic [1:0] acc_off;
  logic       rsp_err;

  assign acc_off = (state == IDLE) ? bus.Req_Addr[1:0] : lat_off;
  assign mis     = (acc_off != 2'b00);

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      lat_off <= 2'b00;
      rsp_err <= 1'b0;
    end else begin
      if (state == IDLE && bus.Req_Valid) lat_off <= bus.Req_Addr[1:0];
      if (do_acc)                         rsp_err <= mis;
    end
  end

  assign bus.Rsp_Err = rsp_err;
`else
  assign mis         = 1'b0;
  assign bus.Rsp_Err = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      cnt       <= '0;
      lat_wr    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
    end else begin
      if (state == IDLE && bus.Req_Valid) begin
        cnt       <= WAIT_W'(WAIT_CYC);
        lat_wr    <= bus.Req_Wr;
        lat_idx   <= bus.Req_Addr[ADDR_W+1:2];
        lat_wdata <= bus.Req_Wdata;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - WAIT_W'(1);
      end
      if (do_acc) rsp_rdata <= (acc_wr || mis) ? '0 : ram_rdata;
    end
  end

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (Clk),
    .we    (do_acc && acc_wr && !mis),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  assign bus.Req_Ready = (state == IDLE);
  assign bus.Rsp_Valid = (state == RESP);
  assign bus.Rsp_Rdata = rsp_rdata;
  assign Busy          = (state != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with WAIT_CYC=2 and one with WAIT_CYC=0.
module tb_dmem_responder;
  logic Clk = 1'b0;
  logic Clrn = 1'b0;
  logic busy2, busy0;
  int   checks = 0;
  int   errors = 0;

  dmem_responder_if bus2 ();
  dmem_responder_if bus0 ();

  dmem_responder #(.ADDR_W(10), .WAIT_CYC(2)) u_dut2 (
    .Clk(Clk), .Clrn(Clrn), .bus(bus2.slave), .Busy(busy2)
  );
  dmem_responder #(.ADDR_W(10), .WAIT_CYC(0)) u_dut0 (
    .Clk(Clk), .Clrn(Clrn), .bus(bus0.slave), .Busy(busy0)
  );

  always #5 Clk = ~Clk;

`ifdef DMEM_ALIGN_CHK_EN
  localparam logic        ALIGN_ON  = 1'b1;
  localparam logic [31:0] WORD10_EXP = 32'hDEADBEEF;
`else
  localparam logic        ALIGN_ON  = 1'b0;
  localparam logic [31:0] WORD10_EXP = 32'hCAFEF00D;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with u_dut2 idle; returns at the negedge after the handshake.
  task automatic txn2(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
    bus2.Req_Valid = 1'b1;
    bus2.Req_Wr    = wr;
    bus2.Req_Addr  = addr;
    bus2.Req_Wdata = wdata;
    bus2.Rsp_Ready = 1'b1;
    @(negedge Clk);
    bus2.Req_Valid = 1'b0;
    lat = 1;
    while (!bus2.Rsp_Valid && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
    rdata = bus2.Rsp_Rdata;
    err   = bus2.Rsp_Err;
    @(negedge Clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    bus2.Req_Valid = 1'b0; bus2.Req_Wr = 1'b0; bus2.Req_Addr = '0; bus2.Req_Wdata = '0;
    bus2.Rsp_Ready = 1'b1;
    bus0.Req_Valid = 1'b0; bus0.Req_Wr = 1'b0; bus0.Req_Addr = '0; bus0.Req_Wdata = '0;
    bus0.Rsp_Ready = 1'b1;

    // Reset state while Clrn is held low.
    @(negedge Clk);
    chk("rst_req_ready", 32'(bus2.Req_Ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus2.Rsp_Valid), 32'd0);
    chk("rst_busy",      32'(busy2),          32'd0);
    chk("rst_rdata",     bus2.Rsp_Rdata,      32'd0);
    chk("rst_err",       32'(bus2.Rsp_Err),   32'd0);
    @(negedge Clk);
    Clrn = 1'b1;
    @(negedge Clk);
    chk("post_rst_ready", 32'(bus2.Req_Ready), 32'd1);

    // Store with explicit per-cycle latency checks.
    bus2.Req_Valid = 1'b1; bus2.Req_Wr = 1'b1; bus2.Req_Addr = 32'h10;
    bus2.Req_Wdata = 32'hDEADBEEF; bus2.Rsp_Ready = 1'b1;
    @(negedge Clk);
    bus2.Req_Valid = 1'b0;
    chk("st_c1_valid", 32'(bus2.Rsp_Valid), 32'd0);
    chk("st_c1_busy",  32'(busy2),          32'd1);
    chk("st_c1_ready", 32'(bus2.Req_Ready), 32'd0);
    @(negedge Clk);
    chk("st_c2_valid", 32'(bus2.Rsp_Valid), 32'd0);
    @(negedge Clk);
    chk("st_c3_valid", 32'(bus2.Rsp_Valid), 32'd1);
    chk("st_c3_rdata", bus2.Rsp_Rdata,      32'd0);
    @(negedge Clk);
    chk("st_done_valid", 32'(bus2.Rsp_Valid), 32'd0);
    chk("st_done_ready", 32'(bus2.Req_Ready), 32'd1);

    txn2(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("ld10_rdata", rd, 32'hDEADBEEF);
    chk("ld10_lat",   32'(lat), 32'd3);
    chk("ld10_err",   32'(er),  32'd0);

    // Backpressure: response held, new request ignored.
    bus2.Rsp_Ready = 1'b0;
    bus2.Req_Valid = 1'b1; bus2.Req_Wr = 1'b0; bus2.Req_Addr = 32'h10;
    @(negedge Clk);
    bus2.Req_Valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("bp_first_valid", 32'(bus2.Rsp_Valid), 32'd1);
    bus2.Req_Valid = 1'b1; bus2.Req_Wr = 1'b1; bus2.Req_Addr = 32'h10;
    bus2.Req_Wdata = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("bp_valid", 32'(bus2.Rsp_Valid), 32'd1);
      chk("bp_rdata", bus2.Rsp_Rdata,      32'hDEADBEEF);
      chk("bp_ready", 32'(bus2.Req_Ready), 32'd0);
    end
    bus2.Req_Valid = 1'b0;
    bus2.Rsp_Ready = 1'b1;
    @(negedge Clk);
    chk("bp_rel_valid", 32'(bus2.Rsp_Valid), 32'd0);
    chk("bp_rel_ready", 32'(bus2.Req_Ready), 32'd1);
    txn2(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("bp_no_store", rd, 32'hDEADBEEF);

    // Address wrap at depth 1024 words.
    txn2(1'b1, 32'h1000, 32'h12345678, rd, er, lat);
    chk("wrap_st_rdata", rd, 32'd0);
    chk("wrap_st_lat",   32'(lat), 32'd3);
    txn2(1'b0, 32'h0000, 32'h0, rd, er, lat);
    chk("wrap_ld", rd, 32'h12345678);

    // Misaligned store.
    txn2(1'b1, 32'h13, 32'hCAFEF00D, rd, er, lat);
    chk("mis_err",   32'(er),  32'(ALIGN_ON));
    chk("mis_rdata", rd,       32'd0);
    chk("mis_lat",   32'(lat), 32'd3);
    txn2(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("mis_word10", rd, WORD10_EXP);
    chk("mis_ld_err", 32'(er), 32'd0);

    // Reset in the middle of a store's wait states.
    bus2.Req_Valid = 1'b1; bus2.Req_Wr = 1'b1; bus2.Req_Addr = 32'h20;
    bus2.Req_Wdata = 32'h55AA55AA;
    @(negedge Clk);
    bus2.Req_Valid = 1'b0;
    Clrn = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus2.Rsp_Valid), 32'd0);
    chk("midrst_busy",  32'(busy2),          32'd0);
    chk("midrst_ready", 32'(bus2.Req_Ready), 32'd1);
    @(negedge Clk);
    @(negedge Clk);
    Clrn = 1'b1;
    @(negedge Clk);
    txn2(1'b0, 32'h20, 32'h0, rd, er, lat);
    checks++;
    assert (rd !== 32'h55AA55AA) else begin
      errors++;
      $error("FAIL midrst_dropped observed=%h expected=not 55aa55aa", rd);
    end

    // Zero wait states: preload four words, then four back-to-back loads.
    for (int i = 0; i < 4; i++) begin
      bus0.Req_Valid = 1'b1; bus0.Req_Wr = 1'b1;
      bus0.Req_Addr  = 32'h40 + 32'(4 * i);
      bus0.Req_Wdata = 32'hA000_0000 + 32'(i);
      @(negedge Clk);
      bus0.Req_Valid = 1'b0;
      chk("w0_st_valid", 32'(bus0.Rsp_Valid), 32'd1);
      @(negedge Clk);
    end
    bus0.Req_Valid = 1'b1; bus0.Req_Wr = 1'b0; bus0.Req_Addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("w0_ld_valid", 32'(bus0.Rsp_Valid), 32'd1);
      chk("w0_ld_rdata", bus0.Rsp_Rdata,      32'hA000_0000 + 32'(i));
      chk("w0_ld_ready", 32'(bus0.Req_Ready), 32'd0);
      if (i == 3) bus0.Req_Valid = 1'b0;
      else        bus0.Req_Addr = 32'h40 + 32'(4 * (i + 1));
      @(negedge Clk);
      chk("w0_gap_valid", 32'(bus0.Rsp_Valid), 32'd0);
      chk("w0_gap_ready", 32'(bus0.Req_Ready), 32'd1);
    end
    chk("w0_end_busy", 32'(busy0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
